// File: rtl/fb_line_reader.sv
// Framebuffer read side: fetches one row per scaled row group
// and streams the pixels into the linebuffer input.
module fb_line_reader #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 180,
   parameter int SCALE  = 2,
   parameter int ADDRW  = 16,
   parameter int DATAW  = 4,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             line_start,
   input  logic             line0,
   input  logic             buf_sel,
   output logic [ADDRW-1:0] fb_addr,
   output logic             fb_re,
   input  logic [DATAW-1:0] fb_data_0,
   input  logic [DATAW-1:0] fb_data_1,
   output logic [DATAW-1:0] lb_data,
   output logic             lb_valid,
   output logic             frame_done,
   output logic             overrun
);

   localparam int COLW = $clog2(WIDTH);
   localparam int ROWW = $clog2(HEIGHT + 1);

   localparam logic [COLW-1:0] COL_LAST = COLW'(WIDTH - 1);
   localparam logic [ROWW-1:0] ROW_LAST = ROWW'(HEIGHT - 1);
   localparam logic [5:0]      SCL_LAST = 6'(SCALE - 1);

   // every valid stage except the one that feeds lb_valid next
   localparam logic [RD_LAT-1:0] LOW_MASK = {RD_LAT{1'b1}} >> 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_WAIT,
      S_FETCH,
      S_DRAIN
   } state_t;

   state_t            state;
   logic [COLW-1:0]   col;
   logic [ROWW-1:0]   row;
   logic [5:0]        scale;
   logic              sel;
   logic [RD_LAT-1:0] vpipe;
   logic [5:0]        scale_nxt;

   assign scale_nxt = (scale == SCL_LAST) ? 6'd0 : scale + 6'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         col        <= '0;
         row        <= '0;
         scale      <= '0;
         sel        <= 1'b0;
         vpipe      <= '0;
         fb_addr    <= '0;
         fb_re      <= 1'b0;
         lb_data    <= '0;
         lb_valid   <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         vpipe      <= RD_LAT'({vpipe, fb_re});
         lb_valid   <= vpipe[RD_LAT-1];
         if (vpipe[RD_LAT-1]) begin
            lb_data <= sel ? fb_data_1 : fb_data_0;
         end

         if (frame_start) begin
            // new frame or abort: drop anything still in flight
            state    <= S_ARMED;
            sel      <= buf_sel;
            fb_addr  <= '0;
            fb_re    <= 1'b0;
            col      <= '0;
            row      <= '0;
            scale    <= '0;
            vpipe    <= '0;
            lb_valid <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  state <= S_IDLE;
               end
               S_ARMED: begin
                  if (line0) begin
                     state <= S_FETCH;
                     scale <= '0;
                     col   <= '0;
                     fb_re <= 1'b1;
                  end
               end
               S_WAIT: begin
                  if (line_start) begin
                     scale <= scale_nxt;
                     if (scale_nxt == 6'd0) begin
                        state <= S_FETCH;
                        col   <= '0;
                        fb_re <= 1'b1;
                     end
                  end
               end
               S_FETCH: begin
                  if (line_start) begin
                     overrun <= 1'b1;
                     scale   <= scale_nxt;
                  end
                  if (col == COL_LAST) begin
                     fb_re <= 1'b0;
                     row   <= row + 1'b1;
                     if (row == ROW_LAST) begin
                        state <= S_DRAIN;
                     end else begin
                        // next row starts right after this one
                        state   <= S_WAIT;
                        fb_addr <= fb_addr + 1'b1;
                     end
                  end else begin
                     col     <= col + 1'b1;
                     fb_addr <= fb_addr + 1'b1;
                  end
               end
               S_DRAIN: begin
                  // pulse lines up with the final lb_valid
                  if ((vpipe & LOW_MASK) == '0) begin
                     frame_done <= 1'b1;
                     state      <= S_IDLE;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fb_line_reader.sv
// Directed bench for fb_line_reader: W=4 H=3 S=2, with a
// second RD_LAT=2 instance alongside for latency checks.
module tb_fb_line_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start, line_start, line0, buf_sel;
   logic [15:0] fb_addr, fb_addr2;
   logic        fb_re, fb_re2;
   logic [3:0]  fb_data_0, fb_data_1, d2_0, d2_1;
   logic [3:0]  lb_data, lb_data2;
   logic        lb_valid, lb_valid2;
   logic        frame_done, frame_done2;
   logic        overrun, overrun2;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;
   int c0, c1;

   logic [15:0] re_addr[$];
   int          re_cyc[$];
   logic [3:0]  lv_data[$];
   int          lv_cyc[$];
   int          lv2_cyc[$];
   int          fd_cyc[$];
   int          ov_cyc[$];

   fb_line_reader #(
      .WIDTH(4), .HEIGHT(3), .SCALE(2),
      .ADDRW(16), .DATAW(4), .RD_LAT(1)
   ) dut (
      .clk(clk), .rst(rst),
      .frame_start(frame_start), .line_start(line_start),
      .line0(line0), .buf_sel(buf_sel),
      .fb_addr(fb_addr), .fb_re(fb_re),
      .fb_data_0(fb_data_0), .fb_data_1(fb_data_1),
      .lb_data(lb_data), .lb_valid(lb_valid),
      .frame_done(frame_done), .overrun(overrun)
   );

   fb_line_reader #(
      .WIDTH(4), .HEIGHT(3), .SCALE(2),
      .ADDRW(16), .DATAW(4), .RD_LAT(2)
   ) dut2 (
      .clk(clk), .rst(rst),
      .frame_start(frame_start), .line_start(line_start),
      .line0(line0), .buf_sel(buf_sel),
      .fb_addr(fb_addr2), .fb_re(fb_re2),
      .fb_data_0(d2_0), .fb_data_1(d2_1),
      .lb_data(lb_data2), .lb_valid(lb_valid2),
      .frame_done(frame_done2), .overrun(overrun2)
   );

   always #5 clk = ~clk;

   // BRAM models: data = address, buffer 1 inverted
   logic [15:0] a1, a2a, a2b;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      a1  <= fb_addr;
      a2a <= fb_addr2;
      a2b <= a2a;
   end
   assign fb_data_0 = a1[3:0];
   assign fb_data_1 = ~a1[3:0];
   assign d2_0      = a2b[3:0];
   assign d2_1      = ~a2b[3:0];

   always @(negedge clk) begin
      if (fb_re) begin
         re_addr.push_back(fb_addr);
         re_cyc.push_back(cyc);
      end
      if (lb_valid) begin
         lv_data.push_back(lb_data);
         lv_cyc.push_back(cyc);
      end
      if (lb_valid2) lv2_cyc.push_back(cyc);
      if (frame_done) fd_cyc.push_back(cyc);
      if (overrun) ov_cyc.push_back(cyc);
   end

   task automatic clear_logs();
      re_addr.delete();
      re_cyc.delete();
      lv_data.delete();
      lv_cyc.delete();
      lv2_cyc.delete();
      fd_cyc.delete();
      ov_cyc.delete();
   endtask

   task automatic pulse(input logic fs, input logic ls, input logic l0);
      frame_start = fs;
      line_start  = ls;
      line0       = l0;
      @(negedge clk);
      frame_start = 1'b0;
      line_start  = 1'b0;
      line0       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      frame_start = 1'b0;
      line_start  = 1'b0;
      line0       = 1'b0;
      buf_sel     = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({fb_re, lb_valid, frame_done, overrun} !== 4'b0) begin
         n_miss++;
         $display("FAIL reset_flags: got %b, required 0000",
                  {fb_re, lb_valid, frame_done, overrun});
      end
      n_vec++;
      if (fb_addr !== 16'd0 || lb_data !== 4'd0) begin
         n_miss++;
         $display("FAIL reset_data: addr %0h data %0h, required 0 0",
                  fb_addr, lb_data);
      end
      n_vec++;
      if ({fb_re2, lb_valid2, frame_done2, overrun2} !== 4'b0 ||
          fb_addr2 !== 16'd0 || lb_data2 !== 4'd0) begin
         n_miss++;
         $display("FAIL reset_dut2: outputs not all zero");
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_frame();
      int       ec;
      logic [3:0] ed;
      #1 clear_logs();
      buf_sel = 1'b1;
      pulse(1'b1, 1'b0, 1'b0);
      buf_sel = 1'b0;
      pulse(1'b0, 1'b1, 1'b0);
      idle(2);
      c0 = cyc;
      pulse(1'b0, 1'b1, 1'b1);
      idle(19);
      for (int k = 1; k < 6; k++) begin
         pulse(1'b0, 1'b1, k == 1);
         idle(19);
      end
      #1;
      n_vec++;
      if (re_addr.size() != 12) begin
         n_miss++;
         $display("FAIL frame_reads: %0d reads, required 12",
                  re_addr.size());
      end
      for (int i = 0; i < 12; i++) begin
         ec = c0 + 1 + 40 * (i / 4) + i % 4;
         n_vec++;
         if (i >= re_addr.size()) begin
            n_miss++;
            $display("FAIL frame_re[%0d]: missing, required addr %0d cyc %0d",
                     i, i, ec - c0);
         end else if (re_addr[i] !== 16'(i) || re_cyc[i] != ec) begin
            n_miss++;
            $display("FAIL frame_re[%0d]: addr %0d cyc %0d, required %0d %0d",
                     i, re_addr[i], re_cyc[i] - c0, i, ec - c0);
         end
      end
      for (int i = 0; i < 12; i++) begin
         ec = c0 + 3 + 40 * (i / 4) + i % 4;
         ed = ~4'(i);
         n_vec++;
         if (i >= lv_data.size()) begin
            n_miss++;
            $display("FAIL frame_lb[%0d]: missing, required %h", i, ed);
         end else if (lv_data[i] !== ed || lv_cyc[i] != ec) begin
            n_miss++;
            $display("FAIL frame_lb[%0d]: data %h cyc %0d, required %h %0d",
                     i, lv_data[i], lv_cyc[i] - c0, ed, ec - c0);
         end
         n_vec++;
         if (i >= lv2_cyc.size() || lv2_cyc[i] != ec + 1) begin
            n_miss++;
            $display("FAIL lat2_lb[%0d]: required cyc %0d", i, ec + 1 - c0);
         end
      end
      n_vec++;
      if (lv_data.size() != 12) begin
         n_miss++;
         $display("FAIL frame_lbcount: %0d, required 12", lv_data.size());
      end
      n_vec++;
      if (fd_cyc.size() != 1 || fd_cyc[0] != c0 + 86) begin
         n_miss++;
         $display("FAIL frame_done: %0d pulses, required 1 at cyc 86",
                  fd_cyc.size());
      end
      n_vec++;
      if (ov_cyc.size() != 0) begin
         n_miss++;
         $display("FAIL frame_overrun: %0d pulses, required 0",
                  ov_cyc.size());
      end
      n_vec++;
      if (fb_addr !== 16'd11) begin
         n_miss++;
         $display("FAIL frame_addr_hold: %0d, required 11", fb_addr);
      end
   endtask

   task automatic test_overrun_abort();
      int         ea[$];
      int         ec[$];
      int         ed[$];
      int         ldc[$];
      #1 clear_logs();
      buf_sel = 1'b0;
      pulse(1'b1, 1'b0, 1'b0);
      idle(2);
      c0 = cyc;
      pulse(1'b0, 1'b0, 1'b1);
      idle(1);
      pulse(1'b0, 1'b1, 1'b0);
      idle(17);
      pulse(1'b0, 1'b1, 1'b0);
      idle(1);
      buf_sel = 1'b1;
      pulse(1'b1, 1'b0, 1'b0);
      n_vec++;
      if (lb_valid !== 1'b0 || fb_re !== 1'b0) begin
         n_miss++;
         $display("FAIL abort_stop: lb_valid %b fb_re %b, required 0 0",
                  lb_valid, fb_re);
      end
      idle(2);
      buf_sel = 1'b0;
      pulse(1'b1, 1'b0, 1'b1);
      idle(3);
      c1 = cyc;
      pulse(1'b0, 1'b0, 1'b1);
      idle(10);
      #1;
      for (int i = 0; i < 4; i++) begin
         ea.push_back(i);
         ec.push_back(c0 + 1 + i);
      end
      ea.push_back(4);
      ec.push_back(c0 + 21);
      ea.push_back(5);
      ec.push_back(c0 + 22);
      for (int i = 0; i < 4; i++) begin
         ea.push_back(i);
         ec.push_back(c1 + 1 + i);
      end
      for (int i = 0; i < 4; i++) begin
         ed.push_back(i);
         ldc.push_back(c0 + 3 + i);
      end
      for (int i = 0; i < 4; i++) begin
         ed.push_back(i);
         ldc.push_back(c1 + 3 + i);
      end
      n_vec++;
      if (ov_cyc.size() != 1 || ov_cyc[0] != c0 + 3) begin
         n_miss++;
         $display("FAIL overrun: %0d pulses, required 1 at cyc 3",
                  ov_cyc.size());
      end
      n_vec++;
      if (re_addr.size() != ea.size()) begin
         n_miss++;
         $display("FAIL abort_reads: %0d reads, required %0d",
                  re_addr.size(), ea.size());
      end
      foreach (ea[i]) begin
         n_vec++;
         if (i >= re_addr.size() || re_addr[i] !== 16'(ea[i]) ||
             re_cyc[i] != ec[i]) begin
            n_miss++;
            $display("FAIL abort_re[%0d]: required addr %0d", i, ea[i]);
         end
      end
      n_vec++;
      if (lv_data.size() != ed.size()) begin
         n_miss++;
         $display("FAIL abort_lbcount: %0d, required %0d",
                  lv_data.size(), ed.size());
      end
      foreach (ed[i]) begin
         n_vec++;
         if (i >= lv_data.size() || lv_data[i] !== 4'(ed[i]) ||
             lv_cyc[i] != ldc[i]) begin
            n_miss++;
            $display("FAIL abort_lb[%0d]: required data %0d", i, ed[i]);
         end
      end
      n_vec++;
      if (fd_cyc.size() != 0) begin
         n_miss++;
         $display("FAIL abort_done: %0d pulses, required 0", fd_cyc.size());
      end
   endtask

   task automatic test_reset_midfetch();
      #1 clear_logs();
      pulse(1'b1, 1'b0, 1'b0);
      idle(2);
      pulse(1'b0, 1'b0, 1'b1);
      idle(1);
      n_vec++;
      if (fb_re !== 1'b1) begin
         n_miss++;
         $display("FAIL midfetch_pre: fb_re %b, required 1", fb_re);
      end
      #1 rst = 1'b1;
      #1;
      n_vec++;
      if ({fb_re, lb_valid, frame_done, overrun} !== 4'b0 ||
          fb_addr !== 16'd0 || lb_data !== 4'd0) begin
         n_miss++;
         $display("FAIL midfetch_rst: re %b lv %b addr %0d data %h, required 0",
                  fb_re, lb_valid, fb_addr, lb_data);
      end
      #1 rst = 1'b0;
      @(negedge clk);
      #1 clear_logs();
      pulse(1'b0, 1'b1, 1'b1);
      idle(6);
      #1;
      n_vec++;
      if (re_addr.size() != 0 || lv_data.size() != 0) begin
         n_miss++;
         $display("FAIL idle_line0: %0d reads, required 0", re_addr.size());
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_overrun_abort();
      test_reset_midfetch();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
